// File: rtl/sdm_pkg.sv
// Shared types and constants for the sigma-delta sample scheduler.
package sdm_pkg;
    localparam int SAMPLE_W = 4;
    localparam int FIFO_DEPTH = 4;
    localparam logic [SAMPLE_W-1:0] MIDSCALE_DEF = 4'd8;

    typedef enum logic [2:0] {IDLE, CLEAR, PRIME, RUN, STOP} sdm_state_t;
endpackage

// File: rtl/sdm_sample_fifo.sv
// 4x4 synchronous sample FIFO; head is valid whenever the FIFO is non-empty.
module sdm_sample_fifo
    import sdm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [SAMPLE_W-1:0] wdata,
    output logic [SAMPLE_W-1:0] head,
    output logic [2:0]          count,
    output logic                full,
    output logic                empty
);
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [1:0] wptr, rptr;
    logic do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 2'd1;
            if (do_pop)  rptr <= rptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    assign head  = mem[rptr];
    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
endmodule

// File: rtl/sdm_sample_scheduler.sv
// Holds each queued sample on the modulator input for OSR clocks and sequences
// modulator clear, FIFO prime, mute, underrun and orderly stop.
module sdm_sample_scheduler
    import sdm_pkg::*;
#(
    parameter int                  OSR       = 16,
    parameter logic [SAMPLE_W-1:0] MIDSCALE  = MIDSCALE_DEF,
    parameter int                  PRIME_LVL = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mute,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    output logic [SAMPLE_W-1:0] x_out,
    output logic                mod_clr,
    output logic                tick,
    output logic                underrun,
    output logic                busy
);
    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

    sdm_state_t state, state_nx;
    logic [PW-1:0] phase;
    logic clr_cnt;
    logic boundary, load, pop;
    logic [SAMPLE_W-1:0] head;
    logic [2:0] count;
    logic full, empty;

    sdm_sample_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .wdata (s_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign boundary = (phase == PH_LAST);

    // load marks the first clock of a new sample period (RUN entry or wrap)
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE:  if (en) state_nx = CLEAR;
            CLEAR: if (clr_cnt) state_nx = PRIME;
            PRIME: begin
                if (!en) state_nx = IDLE;
                else if (count >= 3'(PRIME_LVL)) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (!en) state_nx = STOP;
                    else     load     = 1'b1;
                end
            end
            STOP:    if (boundary) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // muted periods still consume a sample to keep upstream timing intact
    assign pop = load && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            clr_cnt  <= 1'b0;
            x_out    <= MIDSCALE;
            underrun <= 1'b0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == CLEAR) ? ~clr_cnt : 1'b0;

            if ((state_nx inside {RUN, STOP}) && state_nx == state && !boundary)
                phase <= phase + 1'b1;
            else
                phase <= '0;

            if (load) begin
                if (mute)        x_out <= MIDSCALE;
                else if (!empty) x_out <= head;
            end else if (state_nx != RUN) begin
                x_out <= MIDSCALE;
            end

            if (state == IDLE && en)         underrun <= 1'b0;
            else if (load && !mute && empty) underrun <= 1'b1;
        end
    end

    assign s_ready = !full;
    assign mod_clr = (state == CLEAR);
    assign tick    = (state == RUN) && (phase == '0);
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_sdm_sample_scheduler.sv
// Directed bench for sdm_sample_scheduler with a queue-based behavioural model.
module tb_sdm_sample_scheduler;
    localparam int OSR       = 4;
    localparam int PRIME_LVL = 2;
    localparam int M_IDLE = 0, M_CLEAR = 1, M_PRIME = 2, M_RUN = 3, M_STOP = 4;

    logic clk = 1'b0;
    logic rst, en, mute, s_valid;
    logic [3:0] s_data;
    logic s_ready, mod_clr, tick, underrun, busy;
    logic [3:0] x_out;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    sdm_sample_scheduler #(.OSR(OSR), .MIDSCALE(4'd8), .PRIME_LVL(PRIME_LVL)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mute     (mute),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .x_out    (x_out),
        .mod_clr  (mod_clr),
        .tick     (tick),
        .underrun (underrun),
        .busy     (busy)
    );

    // Model: queue of samples, operating mode, cycles into period, current output
    int mq[$];
    int m_mode = M_IDLE;
    int m_ph   = 0;
    int m_clr  = 0;
    int m_x    = 8;
    bit m_unr  = 1'b0;

    task automatic m_take();
        if (mute) begin
            m_x = 8;
            if (mq.size() > 0) void'(mq.pop_front());
        end else if (mq.size() > 0) begin
            m_x = mq.pop_front();
        end else begin
            m_unr = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        bit push;
        int pd;
        push = s_valid && (mq.size() < 4);
        pd   = int'(s_data);
        if (rst) begin
            mq.delete();
            m_mode = M_IDLE;
            m_ph   = 0;
            m_x    = 8;
            m_unr  = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: if (en) begin m_mode = M_CLEAR; m_clr = 2; m_unr = 1'b0; end
                M_CLEAR: begin
                    m_clr--;
                    if (m_clr == 0) m_mode = M_PRIME;
                end
                M_PRIME: begin
                    if (!en) m_mode = M_IDLE;
                    else if (mq.size() >= PRIME_LVL) begin m_mode = M_RUN; m_ph = 0; m_take(); end
                end
                M_RUN: begin
                    if (m_ph == OSR - 1) begin
                        m_ph = 0;
                        if (!en) begin m_mode = M_STOP; m_x = 8; end
                        else m_take();
                    end else m_ph++;
                end
                M_STOP: begin
                    if (m_ph == OSR - 1) begin m_mode = M_IDLE; m_ph = 0; end
                    else m_ph++;
                end
                default: ;
            endcase
            if (push) mq.push_back(pd);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("x_out",    int'(x_out),    m_x);
            chk("mod_clr",  int'(mod_clr),  int'(m_mode == M_CLEAR));
            chk("tick",     int'(tick),     int'(m_mode == M_RUN && m_ph == 0));
            chk("underrun", int'(underrun), int'(m_unr));
            chk("busy",     int'(busy),     int'(m_mode != M_IDLE));
            chk("s_ready",  int'(s_ready),  int'(mq.size() < 4));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mute = 1'b0; s_valid = 1'b0; s_data = 4'd0;
        step(2);
        chk_on = 1'b1;
        chk("rst_x", int'(x_out), 8);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(s_ready), 1);
        chk("rst_clr", int'(mod_clr), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_unr", int'(underrun), 0);

        // start-up: queue 3,5,9 then play
        rst = 1'b0; s_valid = 1'b1; s_data = 4'd3; step();
        s_data = 4'd5; step();
        s_data = 4'd9; step();
        s_valid = 1'b0; en = 1'b1; step();
        chk("clr_1", int'(mod_clr), 1);
        chk("clr_busy", int'(busy), 1);
        step(); chk("clr_2", int'(mod_clr), 1);
        step(); chk("clr_off", int'(mod_clr), 0);
        chk("prime_x", int'(x_out), 8);
        step(); chk("run_x3", int'(x_out), 3); chk("run_tick", int'(tick), 1);
        step(); chk("mid_tick", int'(tick), 0);
        step(3); chk("run_x5", int'(x_out), 5); chk("tick_5", int'(tick), 1);
        step(4); chk("run_x9", int'(x_out), 9);
        step(4); chk("unr_x", int'(x_out), 9); chk("unr_flag", int'(underrun), 1);

        // refill, then stop mid-period
        s_valid = 1'b1; s_data = 4'd7; step();
        s_data = 4'd10; step();
        s_valid = 1'b0; step();
        step(); chk("run_x7", int'(x_out), 7);
        en = 1'b0; step(2); chk("stop_finish", int'(x_out), 7);
        step(2); chk("stop_x", int'(x_out), 8); chk("stop_busy", int'(busy), 1);
        step(3); chk("stop_busy_end", int'(busy), 1);
        step(); chk("idle_busy", int'(busy), 0); chk("idle_unr_sticky", int'(underrun), 1);

        // restart: retained 10 plays first; underrun clears on leaving IDLE
        en = 1'b1; s_valid = 1'b1; s_data = 4'd11; step();
        s_valid = 1'b0; chk("unr_clear", int'(underrun), 0);
        step(3); chk("retained_x", int'(x_out), 10);

        rst = 1'b1; en = 1'b0; step(); rst = 1'b0;
        chk("rst2_busy", int'(busy), 0); chk("rst2_x", int'(x_out), 8);

        // mute and full/concurrent operations
        s_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin s_data = 4'(i); step(); end
        s_valid = 1'b0; chk("full_ready", int'(s_ready), 0);
        en = 1'b1; step(4); chk("m_x1", int'(x_out), 1); chk("pop_ready", int'(s_ready), 1);
        step(); mute = 1'b1;
        step(); chk("mute_mid", int'(x_out), 1);
        step(); s_valid = 1'b1; s_data = 4'd5;
        step(); s_valid = 1'b0;
        chk("mute_p2", int'(x_out), 8); chk("mute_tick", int'(tick), 1); chk("cc_ready", int'(s_ready), 1);
        step(4); chk("mute_p3", int'(x_out), 8);
        step(4); chk("mute_p4", int'(x_out), 8);
        mute = 1'b0;
        step(4); chk("unmute_x5", int'(x_out), 5);
        step(4); chk("drain_x", int'(x_out), 5); chk("drain_unr", int'(underrun), 1);

        // reset mid-RUN
        step(); rst = 1'b1; en = 1'b0; step(); rst = 1'b0;
        chk("rst3_x", int'(x_out), 8); chk("rst3_busy", int'(busy), 0);
        chk("rst3_ready", int'(s_ready), 1); chk("rst3_unr", int'(underrun), 0);

        // en drop in PRIME takes effect immediately
        en = 1'b1; step(4);
        chk("prime_hold", int'(busy), 1); chk("prime_hold_x", int'(x_out), 8);
        en = 1'b0; step(); chk("prime_abort", int'(busy), 0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdm_sample_scheduler.md
# sdm_sample_scheduler

Sample-rate sequencer in front of the 4-bit MASH sigma-delta modulator. It accepts baseband samples over a valid/ready handshake into a 4-deep FIFO and presents one sample to the modulator input for exactly OSR modulator clocks. It also sequences modulator start-up (state clear, FIFO prime), mute, underrun handling and orderly stop.

## Interface
- OSR, 16, modulator clocks per sample; legal range 2..256.
- MIDSCALE, 4'd8, idle/mute code driven to the modulator.
- PRIME_LVL, 2, FIFO occupancy required before RUN starts; legal range 1..4.

- clk  in  1  modulator clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level; 1 = play, 0 = stop after the current sample period.
- mute  in  1  level; sampled at each period boundary.
- s_valid  in  1  upstream sample valid.
- s_data  in  4  upstream sample, unsigned.
- s_ready  out  1  high when FIFO count < 4.
- x_out  out  4  registered sample to the modulator input.
- mod_clr  out  1  clears modulator delay/integrator state.
- tick  out  1  one-cycle pulse on the first clock of each sample period.
- underrun  out  1  sticky; cleared by rst or by the IDLE->CLEAR transition.
- busy  out  1  high in any state other than IDLE.

## Operation
- Write: a transfer occurs when s_valid and s_ready are both high on a clk edge. It is accepted in every state, including IDLE.
- States:
  - IDLE: x_out=MIDSCALE. Leave for CLEAR when en=1.
  - CLEAR: hold mod_clr=1 for exactly 2 cycles, then go to PRIME.
  - PRIME: x_out=MIDSCALE. Go to RUN on the first cycle where count≥PRIME_LVL. If en drops, go to IDLE.
  - RUN: counter phase runs 0..OSR-1 and wraps. At phase==OSR-1 (the period boundary):
    - if mute=1: x_out←MIDSCALE, and the FIFO pops if non-empty (samples are discarded while muted);
    - else if FIFO non-empty: x_out←head and pop;
    - else: x_out holds its previous value and underrun is set.
    - If en=0 at the boundary, go to STOP instead of loading.
  - STOP: x_out=MIDSCALE for one full period (OSR cycles) so the modulator settles, then go to IDLE. The FIFO is retained.
- Phase counter width is $clog2(OSR). It is reset to 0 on entry to RUN.
- Simultaneous push and pop at a boundary: count is unchanged and the data order is preserved. When full (count=4), push and pop in the same cycle is allowed only because s_ready was low, so no push occurs.
- mute and en changes between boundaries have no effect until the next boundary. The one exception is en=0 in PRIME, which takes effect immediately.
- rst in any state, mid-period or mid-CLEAR, returns the block to IDLE on the next edge. It empties the FIFO, sets phase=0, x_out=MIDSCALE, mod_clr=0, underrun=0.

## Timing
- Reset values: s_ready=1, x_out=4'd8, mod_clr=0, tick=0, underrun=0, busy=0.
- en rising in IDLE gives: CLEAR at edge+1, mod_clr high for 2 cycles, PRIME at edge+3.
- PRIME→RUN: the first x_out load happens on the RUN entry edge. tick pulses in that same cycle, with x_out already equal to the head sample.
- In steady state, tick pulses every OSR cycles and x_out updates in the same cycle as tick.
- Sample latency from accepted write to appearing on x_out is at least 1 cycle; it depends on queue depth.
- s_ready is combinational from count only, with no dependence on s_valid.

## Structure
- Shared package sdm_pkg holds:
  - the state enum (IDLE, CLEAR, PRIME, RUN, STOP);
  - the MIDSCALE default;
  - the sample width constant (4).
- One sub-module: sdm_sample_fifo, a 4×4 synchronous FIFO with push, pop, count[2:0], full, empty and head-data output. Data is valid whenever non-empty.

## Test plan
- Reset mid-RUN (OSR=4): after rst, x_out=8, busy=0, s_ready=1, FIFO empty, underrun=0 on the next cycle.
- Start-up with OSR=4: push 3,5,9, then raise en. Required: mod_clr high for 2 cycles; RUN entry with x_out=3; x_out=5 four cycles later, then x_out=9; tick every 4 cycles.
- Underrun: push one sample 6 and play it. At the next boundary x_out stays 6 and underrun=1. The flag stays set until the next IDLE→CLEAR transition.
- Mute: while playing 1,2,3,4, assert mute before the second boundary. Required: x_out=8 for periods 2-4, and the FIFO drains to empty.
- Full and concurrent ops: with 4 entries queued, s_ready=0. At a boundary pop, s_ready rises in the next cycle, and a simultaneous push at count=3 keeps count=3.
- Stop: drop en mid-period. The current sample finishes, then x_out=8 for 4 cycles, then IDLE with busy=0 and the remaining FIFO entries retained.
